// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
//   Bundles the signals between decode, the memory/writeback side and the
//   hazard scoreboard.
//
//   Handshake: decode offers an instruction with id_valid. stall is the
//   inverse of "ready" for that slot and depends on the same-cycle inputs.
//   ld_issue is the accept strobe for loads: it is high exactly when a load
//   is taken into the scoreboard. ld_done_valid is a one-cycle completion
//   pulse and has no back-pressure.
//
//   Decode/memory -> scoreboard:
//     id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_wr_en,
//     id_is_load, flush, ld_done_valid, ld_done_rd
//   Scoreboard -> pipeline:
//     stall, ld_issue, outstanding, full, err_spurious
//   With HAZARD_SCOREBOARD_STATS_EN defined:
//     stats_clr (in), stall_cycles (out)
//
//   modport master : pipeline side (drives the inputs)
//   modport slave  : the scoreboard
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int AW = 5,
    parameter int OW = 3
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    parameter int SW = 16
`endif
);
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd;
    logic          id_wr_en;
    logic          id_is_load;
    logic          flush;
    logic          ld_done_valid;
    logic [AW-1:0] ld_done_rd;
    logic          stall;
    logic          ld_issue;
    logic [OW-1:0] outstanding;
    logic          full;
    logic          err_spurious;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic          stats_clr;
    logic [SW-1:0] stall_cycles;
`endif

    modport master (
`ifdef HAZARD_SCOREBOARD_STATS_EN
        output stats_clr,
        input  stall_cycles,
`endif
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
        output id_wr_en, id_is_load, flush, ld_done_valid, ld_done_rd,
        input  stall, ld_issue, outstanding, full, err_spurious
    );

    modport slave (
`ifdef HAZARD_SCOREBOARD_STATS_EN
        input  stats_clr,
        output stall_cycles,
`endif
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
        input  id_wr_en, id_is_load, flush, ld_done_valid, ld_done_rd,
        output stall, ld_issue, outstanding, full, err_spurious
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//   Per-register load scoreboard between decode and issue. Every load in
//   flight marks its destination pending; decode stalls on a RAW or WAW
//   hazard against a pending register, or when MAX_OUT loads are already
//   outstanding. Loads return from memory one per cycle in any order.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    hazard_scoreboard_if.slave (see the interface for the signals)
//
//   Optional build macro HAZARD_SCOREBOARD_STATS_EN adds a saturating count
//   of stalled cycles (bus.stall_cycles) with a synchronous clear
//   (bus.stats_clr). Without it there is no counter and no extra port.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_OUT = 4,
    parameter int OW      = 3
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    parameter int SW      = 16
`endif
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);

    // Bit 0 exists only so a register index can address the vector directly;
    // it is held at zero because x0 is never tracked.
    logic [NREG-1:0] pending_q, pending_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic            err_q, err_d;

    logic full_w;
    logic raw1_w, raw2_w, waw_w, cap_w;
    logic stall_w, issue_w;

    // True for an index naming a tracked register (not x0, inside NREG).
    function automatic logic tracked(input logic [AW-1:0] idx);
        return (idx != '0) && (int'(idx) < NREG);
    endfunction

    // A pending register that returns in this very cycle is forwarded, so it
    // does not count as a hazard.
    function automatic logic hazard(input logic [NREG-1:0] pend,
                                    input logic            en,
                                    input logic [AW-1:0]   idx,
                                    input logic            done_v,
                                    input logic [AW-1:0]   done_rd);
        return en && tracked(idx) && pend[idx] && !(done_v && (done_rd == idx));
    endfunction

    always_comb begin
        full_w  = (outstanding_q == OW'(MAX_OUT));
        raw1_w  = hazard(pending_q, bus.id_rs1_used, bus.id_rs1,
                         bus.ld_done_valid, bus.ld_done_rd);
        raw2_w  = hazard(pending_q, bus.id_rs2_used, bus.id_rs2,
                         bus.ld_done_valid, bus.ld_done_rd);
        waw_w   = hazard(pending_q, bus.id_wr_en, bus.id_rd,
                         bus.ld_done_valid, bus.ld_done_rd);
        // A return in the same cycle frees a slot for the new load.
        cap_w   = bus.id_is_load && full_w && !bus.ld_done_valid;
        stall_w = bus.id_valid && !bus.flush && (raw1_w || raw2_w || waw_w || cap_w);
        issue_w = bus.id_valid && !bus.flush && !stall_w && bus.id_is_load;
    end

    always_comb begin
        pending_d     = pending_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        // Clear first so a set on the same index wins.
        if (bus.ld_done_valid && tracked(bus.ld_done_rd)) begin
            pending_d[bus.ld_done_rd] = 1'b0;
        end
        if (issue_w && tracked(bus.id_rd)) begin
            pending_d[bus.id_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        // A return with nothing in flight is an error and leaves the count
        // at zero; it is flagged even when a load issues in the same cycle.
        if (bus.ld_done_valid && (outstanding_q == '0)) begin
            err_d = 1'b1;
        end
        if (issue_w && !bus.ld_done_valid) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!issue_w && bus.ld_done_valid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign bus.stall        = stall_w;
    assign bus.ld_issue     = issue_w;
    assign bus.outstanding  = outstanding_q;
    assign bus.full         = full_w;
    assign bus.err_spurious = err_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles; clear has priority.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stats_clr) begin
            stall_cnt_d = '0;
        end else if (stall_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int AW      = 5;
    localparam int MAX_OUT = 4;
    localparam int OW      = 3;

    typedef struct {
        logic          v;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
        logic          fl;
        logic          dv;
        logic [AW-1:0] drd;
        logic          clr;
    } stim_t;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.AW(AW), .OW(OW)) bus ();

    hazard_scoreboard #(
        .NREG(NREG), .AW(AW), .MAX_OUT(MAX_OUT), .OW(OW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // ---------------- reference model ----------------
    // Set of registers awaiting a load result, number of loads in flight,
    // sticky error. Loads issued are also remembered in issue order so the
    // stimulus can return them later in a random order.
    bit        m_pend[NREG];
    int        m_cnt;
    bit        m_err;
    int        m_sc;
    logic [AW-1:0] inflight[$];

    // ---------------- scoreboard ----------------
    logic [6:0]  exp_q[$];  // {stall, ld_issue, outstanding, full, err_spurious}
    logic [15:0] exp_sc_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
        m_sc  = 0;
        inflight.delete();
    endfunction

    // ---------------- driver ----------------
    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.rs1 = '0; s.rs2 = '0; s.u1 = 0; s.u2 = 0; s.rd = '0;
        s.wr = 0; s.ld = 0; s.fl = 0; s.dv = 0; s.drd = '0; s.clr = 0;
        return s;
    endfunction

    // Decode operation; a negative register argument means "not used".
    function automatic stim_t op(input bit ld, input int rs1, input int rs2, input int rd);
        stim_t s = idle();
        s.v   = 1'b1;
        s.ld  = ld;
        s.u1  = (rs1 >= 0);
        s.rs1 = (rs1 >= 0) ? AW'(rs1) : '0;
        s.u2  = (rs2 >= 0);
        s.rs2 = (rs2 >= 0) ? AW'(rs2) : '0;
        s.wr  = (rd >= 0);
        s.rd  = (rd >= 0) ? AW'(rd) : '0;
        return s;
    endfunction

    function automatic stim_t with_ret(input stim_t s, input int drd);
        stim_t r = s;
        r.dv  = 1'b1;
        r.drd = AW'(drd);
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.v   = ($urandom_range(0, 3) != 0);
        s.ld  = ($urandom_range(0, 2) == 0);
        s.rs1 = AW'($urandom_range(0, 7));
        s.rs2 = AW'($urandom_range(0, 7));
        s.u1  = $urandom_range(0, 1);
        s.u2  = $urandom_range(0, 1);
        s.rd  = AW'($urandom_range(0, 7));
        s.wr  = s.ld ? 1'b1 : 1'($urandom_range(0, 1));
        s.fl  = ($urandom_range(0, 9) == 0);
        s.clr = ($urandom_range(0, 15) == 0);
        if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            s.dv  = 1'b1;
            s.drd = inflight[$urandom_range(0, inflight.size() - 1)];
        end else if (inflight.size() == 0 && $urandom_range(0, 49) == 0) begin
            s.dv  = 1'b1;
            s.drd = AW'($urandom_range(0, 7));
        end
        return s;
    endfunction

    // One clock cycle: apply inputs after the edge, queue the expected
    // outputs for this cycle, then advance the model to the next edge.
    task automatic step(input stim_t s, input bit hold_rst);
        bit full, raw1, raw2, waw, cap, stl, iss;
        @(posedge clk);
        #1;
        rst_n = !hold_rst;
        if (hold_rst) model_clear();
        bus.id_valid      = s.v;
        bus.id_rs1        = s.rs1;
        bus.id_rs2        = s.rs2;
        bus.id_rs1_used   = s.u1;
        bus.id_rs2_used   = s.u2;
        bus.id_rd         = s.rd;
        bus.id_wr_en      = s.wr;
        bus.id_is_load    = s.ld;
        bus.flush         = s.fl;
        bus.ld_done_valid = s.dv;
        bus.ld_done_rd    = s.drd;
`ifdef HAZARD_SCOREBOARD_STATS_EN
        bus.stats_clr     = s.clr;
`endif

        full = (m_cnt == MAX_OUT);
        raw1 = s.u1 && s.rs1 != 0 && m_pend[s.rs1] && !(s.dv && s.drd == s.rs1);
        raw2 = s.u2 && s.rs2 != 0 && m_pend[s.rs2] && !(s.dv && s.drd == s.rs2);
        waw  = s.wr && s.rd  != 0 && m_pend[s.rd]  && !(s.dv && s.drd == s.rd);
        cap  = s.ld && full && !s.dv;
        stl  = s.v && !s.fl && (raw1 || raw2 || waw || cap);
        iss  = s.v && !s.fl && !stl && s.ld;
        exp_q.push_back({stl, iss, OW'(m_cnt), full, m_err});
        exp_sc_q.push_back(16'(m_sc));

        if (!hold_rst) begin
            if (s.dv) begin
                if (m_cnt == 0) m_err = 1'b1;
                if (s.drd != 0) m_pend[s.drd] = 1'b0;
                for (int i = 0; i < inflight.size(); i++) begin
                    if (inflight[i] == s.drd) begin
                        inflight.delete(i);
                        break;
                    end
                end
            end
            if (iss) begin
                if (s.rd != 0) m_pend[s.rd] = 1'b1;
                inflight.push_back(s.rd);
            end
            m_cnt = m_cnt + int'(iss) - int'(s.dv);
            if (m_cnt < 0) m_cnt = 0;
            if (s.clr) m_sc = 0;
            else if (stl && m_sc != 16'hFFFF) m_sc = m_sc + 1;
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(rand_stim(), 1'b1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [6:0]  e;
        logic [15:0] esc;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                esc = exp_sc_q.pop_front();
                chk("stall",        16'(bus.stall),        16'(e[6]));
                chk("ld_issue",     16'(bus.ld_issue),     16'(e[5]));
                chk("outstanding",  16'(bus.outstanding),  16'(e[4:2]));
                chk("full",         16'(bus.full),         16'(e[1]));
                chk("err_spurious", 16'(bus.err_spurious), 16'(e[0]));
`ifdef HAZARD_SCOREBOARD_STATS_EN
                chk("stall_cycles", 16'(bus.stall_cycles), esc);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        model_clear();

        // Reset with random inputs driven.
        do_reset(3);

        // Load to x5, three dependent instructions stall, then the return
        // forwards in the same cycle and the scoreboard is empty afterwards.
        step(op(1, 2, -1, 5), 0);
        repeat (3) step(op(0, 5, -1, 6), 0);
        step(with_ret(op(0, 5, -1, 6), 5), 0);
        step(op(0, 5, -1, 6), 0);

        // WAW on x7; x0 never hazards; load to x0 takes a slot only.
        step(op(1, -1, -1, 7), 0);
        step(op(0, 1, -1, 7), 0);
        step(op(0, 0, 0, 0), 0);
        step(op(1, 0, -1, 0), 0);
        step(with_ret(idle(), 0), 0);
        step(with_ret(idle(), 7), 0);

        // Capacity: four loads fill, fifth stalls, then issues with a return.
        for (int r = 1; r <= 4; r++) step(op(1, -1, -1, r), 0);
        step(op(1, -1, -1, 9), 0);
        step(with_ret(op(1, -1, -1, 9), 1), 0);
        step(with_ret(idle(), 2), 0);
        step(with_ret(idle(), 3), 0);
        step(with_ret(idle(), 4), 0);
        step(with_ret(idle(), 9), 0);

        // Flush suppresses stall/issue but leaves the pending bit.
        begin
            stim_t f;
            step(op(1, -1, -1, 5), 0);
            f = op(1, 5, -1, 10);
            f.fl = 1'b1;
            step(f, 0);
            step(op(0, 5, -1, 6), 0);
            step(with_ret(idle(), 5), 0);
        end

        // Spurious return sets the sticky error.
        step(with_ret(idle(), 3), 0);
        repeat (2) step(idle(), 0);

        // Reset mid-flight discards tracking; the late return is spurious.
        step(op(1, -1, -1, 8), 0);
        do_reset(2);
        step(with_ret(op(0, 8, -1, 1), 8), 0);
        step(op(0, 8, -1, 1), 0);

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 300; i++) step(rand_stim(), 0);
        do_reset(2);
        for (int i = 0; i < 300; i++) step(rand_stim(), 0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
